pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Pipeline control unit for the 5-stage ARM core. It drives the PC, IF/ID and ID/EX load enables and the clear controls for those registers. It resolves load-use hazards, taken-branch flushes and data-memory wait stalls. It also keeps saturating stall and flush statistics counters that are readable by the debug logic.

Parameters:
REG_W, 4, register-specifier width (ARM R0-R15)
FLUSH_CYCLES, 1, cycles IF/ID is cleared per taken branch; legal range 1..15
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
id_rn  input  REG_W  Rn specifier of the instruction in ID
id_rm  input  REG_W  Rm specifier of the instruction in ID
id_rn_used  input  1  ID instruction reads Rn
id_rm_used  input  1  ID instruction reads Rm
ex_rd  input  REG_W  destination register of the instruction in EX
ex_load  input  1  EX holds a load (LDR/LDRB) that writes ex_rd
branch_taken  input  1  taken branch resolved in EX, one-cycle pulse
mem_busy  input  1  data memory not ready; hold pipeline
clear_stats  input  1  clears the statistics counters
pc_enable  output  1  PC load enable
if_id_enable  output  1  IF/ID enable
if_id_flush  output  1  IF/ID clear, ORed into that register's reset
id_ex_enable  output  1  ID/EX load enable
id_ex_bubble  output  1  load NOP control word into ID/EX
state  output  2  0=RUN, 1=FLUSH, 2=MEM_WAIT
stall_cycles  output  CNT_W  cycles with pc_enable=0
flush_count  output  CNT_W  number of taken-branch flush events

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Reset: state=RUN, flush counter=0, stall_cycles=0, flush_count=0.
- Outputs during reset cycle: all enables=1, if_id_flush=0, id_ex_bubble=0.
- Enable and flush outputs are combinational from state and inputs. State and counters are registered.
- load_use = ex_load & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd)).
- RUN, priority branch_taken > mem_busy > load_use:
  - branch_taken: pc_enable=1, if_id_flush=1, id_ex_bubble=1, if_id_enable=1, id_ex_enable=1. flush_count+=1. If FLUSH_CYCLES>1, go to FLUSH with remaining counter=FLUSH_CYCLES-1; else stay RUN.
  - mem_busy: pc_enable=0, if_id_enable=0, id_ex_enable=0, id_ex_bubble=0. Go to MEM_WAIT.
  - load_use: pc_enable=0, if_id_enable=0, id_ex_enable=1, id_ex_bubble=1. Stay RUN. Lasts exactly one cycle, because the bubble clears ex_load.
  - Otherwise: all enables=1, if_id_flush=0, id_ex_bubble=0.
- FLUSH:
  - pc_enable=1, if_id_flush=1, id_ex_bubble=1.
  - Decrement the counter; at counter==1, go to RUN.
  - mem_busy, load_use and branch_taken are ignored (the bubbles make branch_taken impossible).
- MEM_WAIT:
  - All enables=0 while mem_busy=1.
  - The first cycle with mem_busy=0 is a release cycle: still frozen, then go to RUN.
  - branch_taken is ignored; EX is frozen and re-presents it in RUN.
- Simultaneous branch_taken and mem_busy in RUN: the flush completes this cycle, then the next cycle re-evaluates mem_busy in RUN.
- stall_cycles: increments on every cycle with pc_enable=0, saturating at all-ones.
- flush_count: saturates at all-ones.
- clear_stats zeroes both counters next edge; it wins over a same-cycle increment. It does not affect state.
- Reset mid-FLUSH or mid-MEM_WAIT: state is RUN on the next cycle, all pending flush and wait is dropped, and counters are zeroed.
- Register 0 is a valid hazard source. There is no zero-register exception.

Test Plan:
- ex_load=1, ex_rd=3, id_rn=3, id_rn_used=1 -> for one cycle pc_enable=0, if_id_enable=0, id_ex_bubble=1; next cycle with ex_load=0, all enables=1; stall_cycles=1.
- Same setup with id_rn_used=0, id_rm=5 -> no stall, all enables=1, stall_cycles unchanged.
- FLUSH_CYCLES=3, branch_taken pulse -> if_id_flush=1 for exactly 3 cycles; state goes RUN, FLUSH, FLUSH, RUN; flush_count=1.
- mem_busy high for 4 cycles -> freeze for 5 cycles (4 plus release); state=2 during the wait; stall_cycles=5.
- branch_taken and mem_busy asserted together -> flush cycle, then MEM_WAIT; flush_count=1.
- CNT_W=4: hold mem_busy for 20 cycles -> stall_cycles saturates at 15. Then reset during MEM_WAIT -> next cycle state=0, counters=0, all enables=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage core. It handles load-use stalls, taken-branch flushes
// and data-memory waits, and keeps saturating stall and flush statistics.
//
// state     | meaning
// RUN       | normal issue; hazards are resolved here
// FLUSH     | IF/ID cleared for the remaining cycles after a taken branch
// MEM_WAIT  | pipeline frozen until data memory releases, plus one release cycle
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_load,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             clear_stats,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state_q, state_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic       load_use;
  logic       flush_evt;

  assign load_use = ex_load & ((id_rn_used & (id_rn == ex_rd)) |
                               (id_rm_used & (id_rm == ex_rd)));
  assign state = state_q;

  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_enable = 1'b1;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    flush_evt    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_evt    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end
        end else if (mem_busy) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_enable = 1'b0;
          state_d      = ST_MEM_WAIT;
        end else if (load_use) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      ST_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        fcnt_d       = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) state_d = ST_RUN;
      end
      ST_MEM_WAIT: begin
        // The release cycle stays frozen; EX re-presents any branch once back in RUN.
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_enable = 1'b0;
        if (!mem_busy) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (reset) begin
      pc_enable    = 1'b1;
      if_id_enable = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_enable = 1'b1;
      id_ex_bubble = 1'b0;
      flush_evt    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      fcnt_q       <= 4'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (clear_stats) begin
        stall_cycles <= '0;
        flush_count  <= '0;
      end else begin
        if (!pc_enable && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_W'(1);
        if (flush_evt && flush_count != CNT_MAX) flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule
